// File: rtl/missle_hit_detect.sv
// missle_hit_detect
// -----------------------------------------------------------------------------
// Collision detector between the flying missile and the enemy table.
// Each new missile position (or a fresh flight) starts a scan of the
// enemy table. Every slot is checked for an exclusive rectangle overlap.
// The first live slot that overlaps produces a one-cycle hit, kill mask
// and missile-kill pulse. The missile then stays retired until
// missle_on_i drops.
//
// Optional build macro:
//   MISSLE_HIT_CNT_EN - adds hit_cnt_o, a saturating 16-bit hit counter.
//
// Ports:
//   pclk_i          pixel clock, sole clock
//   rst_ni          asynchronous active-low reset
//   missle_on_i     missile visible / flying
//   missle_xpos_i   missile top-left x
//   missle_ypos_i   missile top-left y
//   enemy_alive_i   per-slot alive flags, sampled in the compare cycle
//   enemy_idx_o     enemy table read address
//   enemy_xpos_i    x of slot enemy_idx_o, valid one cycle after the address
//   enemy_ypos_i    y of slot enemy_idx_o, valid one cycle after the address
//   hit_o           one-cycle hit pulse
//   hit_idx_o       slot that was hit, held until the next hit
//   kill_mask_o     one-hot of the hit slot, valid only with hit_o
//   hit_cnt_o       (MISSLE_HIT_CNT_EN only) saturating hit count
//   missle_kill_o   one-cycle pulse, same cycle as hit_o
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | wait for a new missile position, or for a new flight
// SCAN  | step through the table addresses; compare runs one slot behind
// DONE  | hit reported; hold until the missile is switched off
// -----------------------------------------------------------------------------
module missle_hit_detect #(
    parameter int ENEMY_NUM = 8,
    parameter int IDX_W     = 3,
    parameter int ENEMY_W   = 48,
    parameter int ENEMY_H   = 64,
    parameter int MISSLE_W  = 10,
    parameter int MISSLE_H  = 20
) (
    input  logic                 pclk_i,
    input  logic                 rst_ni,
    input  logic                 missle_on_i,
    input  logic [10:0]          missle_xpos_i,
    input  logic [10:0]          missle_ypos_i,
    input  logic [ENEMY_NUM-1:0] enemy_alive_i,
    output logic [IDX_W-1:0]     enemy_idx_o,
    input  logic [10:0]          enemy_xpos_i,
    input  logic [10:0]          enemy_ypos_i,
    output logic                 hit_o,
    output logic [IDX_W-1:0]     hit_idx_o,
    output logic [ENEMY_NUM-1:0] kill_mask_o,
`ifdef MISSLE_HIT_CNT_EN
    output logic [15:0]          hit_cnt_o,
`endif
    output logic                 missle_kill_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [11:0]      EW       = 12'(ENEMY_W);
    localparam logic [11:0]      EH       = 12'(ENEMY_H);
    localparam logic [11:0]      MW       = 12'(MISSLE_W);
    localparam logic [11:0]      MH       = 12'(MISSLE_H);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENEMY_NUM - 1);

    state_t                 state_q, state_d;
    logic                   armed_q, armed_d;
    // The snapshot is also the last-seen position used for retriggering.
    logic [10:0]            snap_x_q, snap_x_d;
    logic [10:0]            snap_y_q, snap_y_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       cmp_idx_q, cmp_idx_d;
    logic                   cmp_vld_q, cmp_vld_d;
    logic                   hit_q, hit_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
    logic [ENEMY_NUM-1:0]   kill_mask_q, kill_mask_d;

    logic                   pos_changed;
    logic                   overlap;
    logic [11:0]            sx, sy, ex, ey;

    assign pos_changed = (missle_xpos_i != snap_x_q) || (missle_ypos_i != snap_y_q);

    // The values are widened to 12 bits, so the edge sums cannot wrap.
    // The strict compares make rectangles that only touch count as a miss.
    assign sx = {1'b0, snap_x_q};
    assign sy = {1'b0, snap_y_q};
    assign ex = {1'b0, enemy_xpos_i};
    assign ey = {1'b0, enemy_ypos_i};

    assign overlap = enemy_alive_i[cmp_idx_q]
                     && (sx < ex + EW)
                     && (sx + MW > ex)
                     && (sy < ey + EH)
                     && (sy + MH > ey);

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        idx_d       = idx_q;
        cmp_idx_d   = cmp_idx_q;
        cmp_vld_d   = 1'b0;
        hit_d       = 1'b0;
        hit_idx_d   = hit_idx_q;
        kill_mask_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (!missle_on_i) begin
                    armed_d = 1'b0;
                end else if (!armed_q || pos_changed) begin
                    snap_x_d = missle_xpos_i;
                    snap_y_d = missle_ypos_i;
                    armed_d  = 1'b1;
                    idx_d    = '0;
                    state_d  = ST_SCAN;
                end
            end

            ST_SCAN: begin
                // Abort has priority over an overlap in the same cycle.
                if (!missle_on_i) begin
                    state_d = ST_IDLE;
                end else begin
                    // Table data lags the address by one cycle, so the
                    // slot under test is the previous address.
                    cmp_vld_d = 1'b1;
                    cmp_idx_d = idx_q;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (cmp_vld_q && overlap) begin
                        state_d     = ST_DONE;
                        hit_d       = 1'b1;
                        hit_idx_d   = cmp_idx_q;
                        kill_mask_d = ENEMY_NUM'(1) << cmp_idx_q;
                    end else if (cmp_vld_q && (cmp_idx_q == LAST_IDX)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DONE: begin
                if (!missle_on_i) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            idx_q       <= '0;
            cmp_idx_q   <= '0;
            cmp_vld_q   <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            kill_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            idx_q       <= idx_d;
            cmp_idx_q   <= cmp_idx_d;
            cmp_vld_q   <= cmp_vld_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            kill_mask_q <= kill_mask_d;
        end
    end

`ifdef MISSLE_HIT_CNT_EN
    logic [15:0] hit_cnt_q;

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q <= '0;
        end else if (hit_d && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_q <= hit_cnt_q + 16'd1;
        end
    end

    assign hit_cnt_o = hit_cnt_q;
`endif

    assign enemy_idx_o   = idx_q;
    assign hit_o         = hit_q;
    assign missle_kill_o = hit_q;
    assign hit_idx_o     = hit_idx_q;
    assign kill_mask_o   = kill_mask_q;

endmodule

// File: tb/tb_missle_hit_detect.sv
// Testbench for missle_hit_detect.
// The bench models the enemy table as a registered read.
// A scoreboard queue holds each expected hit as (slot, cycle). The
// monitor pops an entry whenever the DUT reports a hit.
module tb_missle_hit_detect;

    localparam int N    = 8;
    localparam int IDXW = 3;

    logic            pclk;
    logic            rst_n;
    logic            mon;
    logic [10:0]     mx, my;
    logic [N-1:0]    alive;
    logic [IDXW-1:0] enemy_idx;
    logic [10:0]     exq, eyq;
    logic            hit;
    logic [IDXW-1:0] hit_idx;
    logic [N-1:0]    kill_mask;
    logic            mkill;
`ifdef MISSLE_HIT_CNT_EN
    logic [15:0]     hit_cnt;
`endif

    logic [10:0]     tab_x [N];
    logic [10:0]     tab_y [N];

    typedef struct {
        int idx;
        int cyc;
    } sb_t;

    sb_t sb[$];
    sb_t e_mon;
    int  cyc;
    int  total;
    int  bad;

    missle_hit_detect dut (
        .pclk_i        (pclk),
        .rst_ni        (rst_n),
        .missle_on_i   (mon),
        .missle_xpos_i (mx),
        .missle_ypos_i (my),
        .enemy_alive_i (alive),
        .enemy_idx_o   (enemy_idx),
        .enemy_xpos_i  (exq),
        .enemy_ypos_i  (eyq),
        .hit_o         (hit),
        .hit_idx_o     (hit_idx),
        .kill_mask_o   (kill_mask),
`ifdef MISSLE_HIT_CNT_EN
        .hit_cnt_o     (hit_cnt),
`endif
        .missle_kill_o (mkill)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Enemy table: data follows the address by one clock.
    always @(posedge pclk) begin
        exq <= tab_x[enemy_idx];
        eyq <= tab_y[enemy_idx];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Start a flight in the current cycle. If a hit is expected on slot k,
    // it must appear k+3 cycles later.
    task automatic fly(input logic [10:0] x, input logic [10:0] y,
                       input bit exp_hit, input int k);
        mx  = x;
        my  = y;
        mon = 1'b1;
        if (exp_hit) sb.push_back('{k, cyc + k + 3});
    endtask

    task automatic off(input int n);
        mon = 1'b0;
        tick(n);
    endtask

    always @(negedge pclk) begin
        if (rst_n) begin
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                chk("hit_missing", 32'(hit), 32'd1);
                void'(sb.pop_front());
            end
            if (hit) begin
                if (sb.size() == 0) begin
                    chk("spurious_hit", 32'(hit), 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("hit_cyc",     32'(cyc),       32'(e_mon.cyc));
                    chk("hit_idx",     32'(hit_idx),   32'(e_mon.idx));
                    chk("kill_mask",   32'(kill_mask), 32'(1) << e_mon.idx);
                    chk("missle_kill", 32'(mkill),     32'd1);
                end
            end else if (kill_mask != 0 || mkill) begin
                chk("stray_pulse", {23'd0, mkill, kill_mask}, 32'd0);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        mon   = 1'b0;
        mx    = '0;
        my    = '0;
        alive = '0;
        for (int i = 0; i < N; i++) begin
            tab_x[i] = 11'd0;
            tab_y[i] = 11'd0;
        end
        tick(3);
        rst_n = 1'b1;
        tick(2);

        chk("rst_enemy_idx",   32'(enemy_idx), 32'd0);
        chk("rst_hit",         32'(hit),       32'd0);
        chk("rst_hit_idx",     32'(hit_idx),   32'd0);
        chk("rst_kill_mask",   32'(kill_mask), 32'd0);
        chk("rst_missle_kill", 32'(mkill),     32'd0);

        // Single overlapping slot 3: hit 6 cycles after the trigger.
        tab_x[3] = 11'd380; tab_y[3] = 11'd280;
        alive = 8'h08;
        fly(11'd400, 11'd300, 1'b1, 3);
        tick(12);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        chk("t1_hit_idx_held", 32'(hit_idx), 32'd3);
        off(3);

        // Slot 3 is dead: full scan, address stops at 7, back in IDLE at T+10.
        alive = 8'h00;
        fly(11'd400, 11'd300, 1'b0, 0);
        tick(9);
        chk("t2_enemy_idx_last", 32'(enemy_idx), 32'd7);
        tick(1);
        alive = 8'h08;
        fly(11'd401, 11'd300, 1'b1, 3);
        tick(12);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        off(3);

        // Horizontal edge: sx == ex+48 misses, one pixel left hits.
        alive = 8'h01;
        tab_x[0] = 11'd352; tab_y[0] = 11'd300;
        fly(11'd400, 11'd300, 1'b0, 0);
        tick(12);
        off(3);
        fly(11'd399, 11'd300, 1'b1, 0);
        tick(12);
        off(3);
        // Vertical edge: sy+20 == ey misses, one pixel lower hits.
        tab_x[0] = 11'd380; tab_y[0] = 11'd320;
        fly(11'd400, 11'd300, 1'b0, 0);
        tick(12);
        off(3);
        fly(11'd400, 11'd301, 1'b1, 0);
        tick(12);
        off(3);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Slots 2 and 5 overlap: the lowest index wins, with one hit per flight.
        tab_x[0] = 11'd0;   tab_y[0] = 11'd0;
        tab_x[2] = 11'd390; tab_y[2] = 11'd290;
        tab_x[5] = 11'd395; tab_y[5] = 11'd310;
        alive = 8'h24;
        fly(11'd400, 11'd300, 1'b1, 2);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            my = 11'(300 + i + 1);
        end
        chk("t4_one_hit_per_flight", 32'(sb.size()), 32'd0);
        off(2);
        fly(11'd400, 11'd300, 1'b1, 2);
        tick(12);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        off(3);

        // Abort at SCAN cycle 3 with slot 4 overlapping; IDLE on the next cycle.
        tab_x[4] = 11'd390; tab_y[4] = 11'd290;
        alive = 8'h10;
        fly(11'd400, 11'd300, 1'b0, 0);
        tick(4);
        mon = 1'b0;
        tick(1);
        fly(11'd401, 11'd300, 1'b1, 4);
        tick(12);
        off(3);
        // Abort in the same cycle that slot 4 is compared.
        fly(11'd400, 11'd300, 1'b0, 0);
        tick(6);
        mon = 1'b0;
        tick(1);
        fly(11'd402, 11'd300, 1'b1, 4);
        tick(12);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        chk("t5_hit_idx_held", 32'(hit_idx), 32'd4);
        off(3);

        // Asynchronous reset at SCAN cycle 2 clears outputs at once.
        fly(11'd400, 11'd300, 1'b0, 0);
        tick(3);
        #1;
        rst_n = 1'b0;
        mon   = 1'b0;
        #1;
        chk("ar_enemy_idx",   32'(enemy_idx), 32'd0);
        chk("ar_hit",         32'(hit),       32'd0);
        chk("ar_hit_idx",     32'(hit_idx),   32'd0);
        chk("ar_kill_mask",   32'(kill_mask), 32'd0);
        chk("ar_missle_kill", 32'(mkill),     32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(15);
        chk("ar_sb_empty", 32'(sb.size()), 32'd0);

`ifdef MISSLE_HIT_CNT_EN
        chk("cnt_after_rst", 32'(hit_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            fly(11'd400, 11'd300, 1'b1, 4);
            tick(10);
            off(3);
        end
        chk("cnt_three_hits", 32'(hit_cnt), 32'd3);
`endif

        tick(5);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
